// File: rtl/nios2_hex_ctrl.sv
// Avalon-MM slave driving six active-low seven-segment digits, with optional
// blinking, circular scrolling of the 24-bit VALUE and per-digit decimal points.
module nios2_hex_ctrl #(
  parameter logic [15:0] RESET_PERIOD = 16'd49999,
  parameter logic [23:0] RESET_VALUE  = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam logic [31:0] CTRL_MASK = 32'h003F_033F;

  logic [23:0] value_q, value_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [15:0] period_q, period_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  scroll_pos_q, scroll_pos_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  hex_q [6];
  logic [7:0]  hex_d [6];

  logic        wr_en, wr_value, wr_ctrl, wr_period, tick;
  logic [3:0]  sum [6];
  logic [2:0]  k [6];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    wr_en     = chipselect && !write_n;
    wr_value  = wr_en && (address == 2'd0);
    wr_ctrl   = wr_en && (address == 2'd1);
    wr_period = wr_en && (address == 2'd2);
    // A PERIOD write reloads the counter and swallows a tick due this cycle.
    tick      = (cnt_q == 16'd0) && !wr_period;

    value_d  = wr_value  ? writedata[23:0] : value_q;
    ctrl_d   = wr_ctrl   ? (writedata & CTRL_MASK) : ctrl_q;
    period_d = wr_period ? writedata[15:0] : period_q;

    if (wr_period)            cnt_d = writedata[15:0];
    else if (cnt_q == 16'd0)  cnt_d = period_q;
    else                      cnt_d = cnt_q - 16'd1;

    blink_phase_d = blink_phase_q;
    if (tick && ctrl_q[8]) blink_phase_d = !blink_phase_q;
    if (wr_ctrl && !writedata[8]) blink_phase_d = 1'b0;

    scroll_pos_d = scroll_pos_q;
    if (tick && ctrl_q[9]) scroll_pos_d = (scroll_pos_q == 3'd5) ? 3'd0 : scroll_pos_q + 3'd1;
    if (wr_ctrl && !writedata[9]) scroll_pos_d = 3'd0;
  end

  // Outputs are built from the registered state, so they trail it by one edge.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      sum[i]   = 4'(i) + {1'b0, scroll_pos_q};
      k[i]     = (sum[i] >= 4'd6) ? 3'(sum[i] - 4'd6) : sum[i][2:0];
      hex_d[i] = {~ctrl_q[16+i], seg7(value_q[{k[i], 2'b00} +: 4])};
      if (!ctrl_q[i] || (ctrl_q[8] && blink_phase_q)) hex_d[i] = 8'hFF;
    end
  end

  always_comb begin
    readdata = 32'h0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = {8'h0, value_q};
        2'd1:    readdata = ctrl_q;
        2'd2:    readdata = {16'h0, period_q};
        default: readdata = {28'h0, blink_phase_q, scroll_pos_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q       <= RESET_VALUE;
      ctrl_q        <= 32'h0;
      period_q      <= RESET_PERIOD;
      cnt_q         <= RESET_PERIOD;
      scroll_pos_q  <= 3'd0;
      blink_phase_q <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= 8'hFF;
    end else begin
      value_q       <= value_d;
      ctrl_q        <= ctrl_d;
      period_q      <= period_d;
      cnt_q         <= cnt_d;
      scroll_pos_q  <= scroll_pos_d;
      blink_phase_q <= blink_phase_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule
